python_reg_seq: RTL and testbench

PYTHON_REG_SEQ -- requirements
Module: python_reg_seq

---
 rtl/python_reg_seq_pkg.sv | 70 +++++++
 rtl/python_reg_seq_rom.sv | 26 ++
 rtl/python_reg_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_python_reg_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/python_reg_seq_pkg.sv
// Shared types, helpers and the sensor power-up command table for python_reg_seq.
// Entry layout: {op[31:30], reserved[29:25], addr[24:16], data[15:0]}.
package python_reg_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_VERIFY = 2'd1,
    OP_WAIT   = 2'd2,
    OP_END    = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rsvd;
    logic [8:0]  addr;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_DELAY  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [15:0] CHIP_ID = 16'h5004;

  function automatic entry_t make_entry(input op_e op, input logic [8:0] addr,
                                        input logic [15:0] data);
    entry_t e;
    e.op   = op;
    e.rsvd = 5'd0;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Chip-ID check, clock/PLL bring-up, settle, then the config write.
  function automatic entry_t power_up_entry(input logic [31:0] idx);
    entry_t e;
    case (idx)
      32'd0:   e = make_entry(OP_VERIFY, 9'h000, CHIP_ID);
      32'd1:   e = make_entry(OP_WRITE,  9'h007, 16'h0001);
      32'd2:   e = make_entry(OP_WRITE,  9'h008, 16'h0000);
      32'd3:   e = make_entry(OP_WAIT,   9'h000, 16'd5);
      32'd4:   e = make_entry(OP_WRITE,  9'h010, 16'h1234);
      32'd5:   e = make_entry(OP_WAIT,   9'h000, 16'd0);
      default: e = make_entry(OP_END,    9'h000, 16'h0000);
    endcase
    return e;
  endfunction

  // WAIT length in clk cycles; saturates instead of wrapping on huge products.
  function automatic logic [31:0] delay_cycles(input logic [15:0] ticks,
                                               input logic [31:0] unit);
    logic [47:0] prod;
    logic [31:0] res;
    prod = {32'd0, ticks} * {16'd0, unit};
    if (prod[47:32] != 16'd0) begin
      res = 32'hFFFF_FFFF;
    end else begin
      res = prod[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/python_reg_seq_rom.sv
// Synchronous-read command table holding the sensor power-up sequence.
module python_reg_seq_rom
  import python_reg_seq_pkg::*;
#(
  parameter int TABLE_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [$clog2(TABLE_DEPTH)-1:0] i_addr,
  output entry_t                         o_entry
);

  entry_t r_entry;

  // One-cycle read latency from i_addr to o_entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_entry <= '0;
    end else begin
      r_entry <= power_up_entry(32'(i_addr));
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/python_reg_seq.sv
// python_reg_seq: walks the command table and turns it into SPI register
// writes, read-back verifies and timed waits for sensor power-up.
module python_reg_seq
  import python_reg_seq_pkg::*;
#(
  parameter int TABLE_DEPTH = 64,
  parameter int DELAY_UNIT  = 72,
  parameter int RD_TIMEOUT  = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(TABLE_DEPTH)-1:0] err_index,
  output logic [8:0]                     m_spi_addr,
  output logic                           m_spi_we,
  output logic [15:0]                    m_spi_wdata,
  output logic                           m_spi_valid,
  input  logic                           m_spi_ready,
  input  logic [15:0]                    s_spi_rdata,
  input  logic                           s_spi_rvalid
);

  localparam int               IDX_W    = $clog2(TABLE_DEPTH);
  localparam int               TO_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RD_TIMEOUT - 1);
  localparam logic [31:0]      UNIT_CYC = 32'(DELAY_UNIT);

  state_e           r_state, w_state_nxt, w_step_state;
  op_e              r_op, w_op_nxt;
  entry_t           w_rom_entry;
  logic [IDX_W-1:0] r_index, w_index_nxt, w_step_index;
  logic [IDX_W-1:0] r_err_index, w_err_index_nxt;
  logic [15:0]      r_data, w_data_nxt;
  logic [31:0]      r_delay_cnt, w_delay_nxt, w_wait_cyc;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
  logic [8:0]       r_addr, w_addr_nxt;
  logic             r_we, w_we_nxt;
  logic [15:0]      r_wdata, w_wdata_nxt;
  logic             r_valid, w_valid_nxt;
  logic             w_at_last, w_abort, w_unused_rsvd;

  // Table is addressed with the next index so FETCH sees its entry in one cycle.
  python_reg_seq_rom #(
    .TABLE_DEPTH(TABLE_DEPTH)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .i_addr  (w_index_nxt),
    .o_entry (w_rom_entry)
  );

  assign w_unused_rsvd = ^w_rom_entry.rsvd;
  assign w_wait_cyc    = delay_cycles(w_rom_entry.data, UNIT_CYC);

  // Completing the last table slot ends the pass; the index never wraps.
  assign w_at_last    = (r_index == LAST_IDX);
  assign w_step_state = w_at_last ? ST_DONE : ST_FETCH;
  assign w_step_index = w_at_last ? r_index : r_index + IDX_W'(1);

  // A request already on the bus is never retracted, so abort waits for it.
  assign w_abort = !enable && !((r_state == ST_ISSUE) && !m_spi_ready);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_op_nxt        = r_op;
    w_data_nxt      = r_data;
    w_delay_nxt     = r_delay_cnt;
    w_to_nxt        = r_to_cnt;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_err_index_nxt = r_err_index;
    w_addr_nxt      = r_addr;
    w_we_nxt        = r_we;
    w_wdata_nxt     = r_wdata;
    w_valid_nxt     = r_valid;
    w_busy_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (enable && !r_done && !r_error) begin
          w_state_nxt = ST_FETCH;
          w_index_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FETCH: begin
        w_op_nxt   = w_rom_entry.op;
        w_data_nxt = w_rom_entry.data;
        case (w_rom_entry.op)
          OP_WRITE, OP_VERIFY: begin
            w_state_nxt = ST_ISSUE;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = w_rom_entry.addr;
            w_we_nxt    = (w_rom_entry.op == OP_WRITE);
            w_wdata_nxt = (w_rom_entry.op == OP_WRITE) ? w_rom_entry.data : 16'h0000;
          end
          OP_WAIT: begin
            w_delay_nxt = w_wait_cyc;
            if (w_wait_cyc == 32'd0) begin
              w_state_nxt = w_step_state;
              w_index_nxt = w_step_index;
              w_done_nxt  = w_at_last;
            end else begin
              w_state_nxt = ST_DELAY;
            end
          end
          OP_END: begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
          default: begin
            w_state_nxt     = ST_ERROR;
            w_error_nxt     = 1'b1;
            w_err_index_nxt = r_index;
          end
        endcase
      end

      ST_ISSUE: begin
        if (m_spi_ready) begin
          w_valid_nxt = 1'b0;
          if (r_op == OP_VERIFY) begin
            w_state_nxt = ST_RDWAIT;
            w_to_nxt    = '0;
          end else begin
            w_state_nxt = w_step_state;
            w_index_nxt = w_step_index;
            w_done_nxt  = w_at_last;
          end
        end else begin
          w_valid_nxt = 1'b1;
        end
      end

      ST_RDWAIT: begin
        if (s_spi_rvalid) begin
          if (s_spi_rdata == r_data) begin
            w_state_nxt = w_step_state;
            w_index_nxt = w_step_index;
            w_done_nxt  = w_at_last;
          end else begin
            w_state_nxt     = ST_ERROR;
            w_error_nxt     = 1'b1;
            w_err_index_nxt = r_index;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt     = ST_ERROR;
          w_error_nxt     = 1'b1;
          w_err_index_nxt = r_index;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end

      ST_DELAY: begin
        if (r_delay_cnt <= 32'd1) begin
          w_delay_nxt = 32'd0;
          w_state_nxt = w_step_state;
          w_index_nxt = w_step_index;
          w_done_nxt  = w_at_last;
        end else begin
          w_delay_nxt = r_delay_cnt - 32'd1;
        end
      end

      ST_DONE, ST_ERROR: begin
        w_state_nxt = r_state;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt     = ST_IDLE;
      w_index_nxt     = '0;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
      w_err_index_nxt = '0;
      w_valid_nxt     = 1'b0;
      w_we_nxt        = 1'b0;
      w_addr_nxt      = 9'd0;
      w_wdata_nxt     = 16'h0000;
      w_delay_nxt     = 32'd0;
      w_to_nxt        = '0;
      w_busy_nxt      = 1'b0;
    end else begin
      w_busy_nxt = (w_state_nxt inside {ST_FETCH, ST_ISSUE, ST_RDWAIT, ST_DELAY});
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WRITE;
      r_index     <= '0;
      r_data      <= 16'h0000;
      r_delay_cnt <= 32'd0;
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_addr      <= 9'd0;
      r_we        <= 1'b0;
      r_wdata     <= 16'h0000;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_index     <= w_index_nxt;
      r_data      <= w_data_nxt;
      r_delay_cnt <= w_delay_nxt;
      r_to_cnt    <= w_to_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_index <= w_err_index_nxt;
      r_addr      <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_wdata     <= w_wdata_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign err_index   = r_err_index;
  assign m_spi_addr  = r_addr;
  assign m_spi_we    = r_we;
  assign m_spi_wdata = r_wdata;
  assign m_spi_valid = r_valid;

endmodule

// File: tb/tb_python_reg_seq.sv
// Directed bench for python_reg_seq: main instance (DELAY_UNIT=4, RD_TIMEOUT=16)
// plus a TABLE_DEPTH=4 instance whose table is cut off before its END entry.
module tb_python_reg_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        busy, done, error;
  logic [5:0]  err_index;
  logic [8:0]  m_spi_addr;
  logic        m_spi_we;
  logic [15:0] m_spi_wdata;
  logic        m_spi_valid;
  logic        m_spi_ready;
  logic [15:0] s_spi_rdata;
  logic        s_spi_rvalid;

  logic        enable2;
  logic        busy2, done2, error2;
  logic [1:0]  err_index2;
  logic [8:0]  addr2;
  logic        we2;
  logic [15:0] wdata2;
  logic        valid2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  python_reg_seq #(.TABLE_DEPTH(64), .DELAY_UNIT(4), .RD_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .m_spi_addr(m_spi_addr),
    .m_spi_we(m_spi_we), .m_spi_wdata(m_spi_wdata), .m_spi_valid(m_spi_valid),
    .m_spi_ready(m_spi_ready), .s_spi_rdata(s_spi_rdata), .s_spi_rvalid(s_spi_rvalid)
  );

  python_reg_seq #(.TABLE_DEPTH(4), .DELAY_UNIT(4), .RD_TIMEOUT(16)) dut_short (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .busy(busy2), .done(done2),
    .error(error2), .err_index(err_index2), .m_spi_addr(addr2),
    .m_spi_we(we2), .m_spi_wdata(wdata2), .m_spi_valid(valid2),
    .m_spi_ready(1'b1), .s_spi_rdata(16'h5004), .s_spi_rvalid(1'b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rvalid_pulse(input logic [15:0] d);
    s_spi_rdata  = d;
    s_spi_rvalid = 1'b1;
    tick();
    s_spi_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0; m_spi_ready = 1'b0;
    s_spi_rdata = 16'h0000; s_spi_rvalid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    n_checks++;
    if ({busy, done, error, m_spi_valid, m_spi_we} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, m_spi_valid, m_spi_we});
    else n_pass++;
    n_checks++;
    if ({err_index, m_spi_addr, m_spi_wdata} !== 31'd0)
      $display("FAIL reset_buses: got %0h expected 0", {err_index, m_spi_addr, m_spi_wdata});
    else n_pass++;
    tick();
  endtask

  task automatic test_full_pass();
    int n;
    logic busy_ok;
    enable = 1'b1; m_spi_ready = 1'b1;
    n = 0;
    while (!m_spi_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (n !== 2 || m_spi_addr !== 9'h000 || m_spi_we !== 1'b0)
      $display("FAIL verify_req: got lat=%0d addr=%0h we=%b expected lat=2 addr=0 we=0", n, m_spi_addr, m_spi_we);
    else n_pass++;
    tick();
    rvalid_pulse(16'h5004);
    tick();
    n_checks++;
    if ({m_spi_valid, m_spi_we, m_spi_addr, m_spi_wdata} !== {1'b1, 1'b1, 9'h007, 16'h0001})
      $display("FAIL write1: got v=%b we=%b a=%0h d=%0h expected 1 1 7 1", m_spi_valid, m_spi_we, m_spi_addr, m_spi_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (m_spi_valid !== 1'b0) $display("FAIL valid_gap: got %b expected 0", m_spi_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({m_spi_valid, m_spi_addr, m_spi_wdata} !== {1'b1, 9'h008, 16'h0000})
      $display("FAIL write2: got v=%b a=%0h d=%0h expected 1 8 0", m_spi_valid, m_spi_addr, m_spi_wdata);
    else n_pass++;
    n = 0; busy_ok = 1'b1;
    do begin
      tick(); n++;
      if (!busy) busy_ok = 1'b0;
    end while (!m_spi_valid && n < 40);
    n_checks++;
    if (n !== 23 || busy_ok !== 1'b1)
      $display("FAIL wait_gap: got %0d cycles busy_ok=%b expected 23 busy_ok=1", n, busy_ok);
    else n_pass++;
    n_checks++;
    if ({m_spi_addr, m_spi_wdata, m_spi_we} !== {9'h010, 16'h1234, 1'b1})
      $display("FAIL write3: got a=%0h d=%0h we=%b expected 10 1234 1", m_spi_addr, m_spi_wdata, m_spi_we);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({done, busy} !== 2'b01) $display("FAIL wait0_fetch: got done,busy=%b expected 01", {done, busy});
    else n_pass++;
    tick();
    n_checks++;
    if ({done, busy, error} !== 3'b100) $display("FAIL done_end: got done,busy,err=%b expected 100", {done, busy, error});
    else n_pass++;
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (m_spi_valid || !done) n++; end
    n_checks++;
    if (n !== 0) $display("FAIL done_sticky: got %0d bad cycles expected 0", n);
    else n_pass++;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL done_clear: got done,busy=%b expected 00", {done, busy});
    else n_pass++;
  endtask

  task automatic test_ready_stall();
    int bad;
    int hs;
    enable = 1'b1; m_spi_ready = 1'b1;
    tick(); tick(); tick();
    rvalid_pulse(16'h5004);
    m_spi_ready = 1'b0;
    tick();
    bad = 0; hs = 0;
    for (int i = 0; i < 10; i++) begin
      if ({m_spi_valid, m_spi_we, m_spi_addr, m_spi_wdata} !== {1'b1, 1'b1, 9'h007, 16'h0001}) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0 || m_spi_valid !== 1'b1)
      $display("FAIL stall_stable: got %0d unstable cycles valid=%b expected 0 1", bad, m_spi_valid);
    else n_pass++;
    m_spi_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (m_spi_valid && m_spi_addr == 9'h007) hs++;
      tick();
    end
    n_checks++;
    if (hs !== 1 || m_spi_addr !== 9'h008)
      $display("FAIL stall_handshake: got hs=%0d addr=%0h expected 1 8", hs, m_spi_addr);
    else n_pass++;
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_verify_mismatch();
    enable = 1'b1; m_spi_ready = 1'b1;
    tick(); tick(); tick();
    rvalid_pulse(16'h5000);
    n_checks++;
    if ({error, done, busy, err_index} !== {3'b100, 6'd0})
      $display("FAIL mismatch: got err,done,busy=%b idx=%0d expected 100 0", {error, done, busy}, err_index);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({error, m_spi_valid} !== 2'b10) $display("FAIL error_sticky: got err,valid=%b expected 10", {error, m_spi_valid});
    else n_pass++;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({error, err_index} !== 7'd0) $display("FAIL error_clear: got err=%b idx=%0d expected 0 0", error, err_index);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    enable = 1'b1; m_spi_ready = 1'b1;
    tick(); tick(); tick();
    n = 0;
    while (!error && n < 40) begin tick(); n++; end
    n_checks++;
    if (n !== 16 || err_index !== 6'd0 || busy !== 1'b0)
      $display("FAIL timeout: got %0d cycles idx=%0d busy=%b expected 16 0 0", n, err_index, busy);
    else n_pass++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort_issue();
    int bad;
    enable = 1'b1; m_spi_ready = 1'b0;
    tick(); tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (!m_spi_valid || !busy) bad++; end
    n_checks++;
    if (bad !== 0) $display("FAIL no_retract: got %0d dropped cycles expected 0", bad);
    else n_pass++;
    m_spi_ready = 1'b1;
    tick();
    n_checks++;
    if ({m_spi_valid, busy} !== 2'b00) $display("FAIL abort_after_hs: got valid,busy=%b expected 00", {m_spi_valid, busy});
    else n_pass++;
    rvalid_pulse(16'h5000);
    tick();
    n_checks++;
    if ({busy, error, done, m_spi_valid} !== 4'b0000)
      $display("FAIL rvalid_idle: got busy,err,done,valid=%b expected 0000", {busy, error, done, m_spi_valid});
    else n_pass++;
  endtask

  task automatic test_abort_delay_reset();
    int n;
    enable = 1'b1; m_spi_ready = 1'b1;
    tick(); tick(); tick();
    rvalid_pulse(16'h5004);
    n = 0;
    while (!(m_spi_valid && m_spi_addr == 9'h008) && n < 10) begin tick(); n++; end
    tick(); tick(); tick();
    n_checks++;
    if (busy !== 1'b1 || n > 9) $display("FAIL reach_delay: got busy=%b wait=%0d expected 1 <10", busy, n);
    else n_pass++;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({busy, m_spi_valid, done, error} !== 4'b0000)
      $display("FAIL abort_delay: got busy,valid,done,err=%b expected 0000", {busy, m_spi_valid, done, error});
    else n_pass++;
    enable = 1'b1;
    n = 0;
    while (!m_spi_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (n !== 2 || m_spi_addr !== 9'h000) $display("FAIL restart_idx0: got lat=%0d addr=%0h expected 2 0", n, m_spi_addr);
    else n_pass++;
    tick();
    rvalid_pulse(16'h5004);
    m_spi_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if ({busy, done, error, m_spi_valid, m_spi_we, err_index, m_spi_addr, m_spi_wdata} !== 36'd0)
      $display("FAIL reset_mid_issue: got %0h expected 0",
               {busy, done, error, m_spi_valid, m_spi_we, err_index, m_spi_addr, m_spi_wdata});
    else n_pass++;
    m_spi_ready = 1'b1;
    n = 0;
    while (!m_spi_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (n !== 2 || m_spi_addr !== 9'h000 || m_spi_we !== 1'b0)
      $display("FAIL reset_restart: got lat=%0d addr=%0h we=%b expected 2 0 0", n, m_spi_addr, m_spi_we);
    else n_pass++;
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_last_index();
    int n;
    int hs;
    enable2 = 1'b1;
    n = 0; hs = 0;
    while (!done2 && n < 60) begin tick(); n++; if (valid2) hs++; end
    n_checks++;
    if (n !== 29 || hs !== 3) $display("FAIL last_idx_done: got %0d cycles %0d reqs expected 29 3", n, hs);
    else n_pass++;
    n_checks++;
    if ({busy2, error2, addr2} !== {2'b00, 9'h008}) $display("FAIL last_idx_state: got busy,err=%b addr=%0h expected 00 8", {busy2, error2}, addr2);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (valid2 || !done2) n++; end
    n_checks++;
    if (n !== 0) $display("FAIL no_wrap: got %0d bad cycles expected 0", n);
    else n_pass++;
    enable2 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_ready_stall();
    test_verify_mismatch();
    test_timeout();
    test_abort_issue();
    test_abort_delay_reset();
    test_last_index();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
